// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
//  Module   : dmem_port_arbiter_if
//  Brief    : Bus bundle between the data-memory arbiter, its two requesters
//             (core MEM stage and debug/loader) and the single-port memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) ();
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ack;
    logic              core_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              grant_core;
    logic              grant_dbg;
    logic              busy;

    // Arbiter side: serves both requesters and drives the memory.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output core_rdata, core_ack, core_stall,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant_core, grant_dbg, busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  core_rdata, core_ack, core_stall,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant_core, grant_dbg, busy
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
//  Module   : dmem_port_arbiter
//  Brief    : Core/debug arbiter for a fixed-latency single-port data memory,
//             core priority with a bounded starvation streak for debug.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int c_CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int c_STRK_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_STRK_W-1:0] r_streak;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_gnt_core;
    logic                r_gnt_dbg;
    logic                r_mem_en;
    logic                r_core_ack;
    logic                r_dbg_ack;
    logic [DATA_W-1:0]   r_core_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_streak_full;
    logic                w_pick_core;
    logic                w_pick_dbg;

    // Core loses a tie only once it has won STARVE_LIM times in a row over a waiting dbg.
    assign w_streak_full = (r_streak == c_STRK_W'(STARVE_LIM));
    assign w_pick_core   = bus.core_req && !(bus.dbg_req && w_streak_full);
    assign w_pick_dbg    = !w_pick_core && bus.dbg_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_streak     <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_gnt_core   <= 1'b0;
            r_gnt_dbg    <= 1'b0;
            r_mem_en     <= 1'b0;
            r_core_ack   <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_mem_en   <= 1'b0;
            r_core_ack <= 1'b0;
            r_dbg_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_core || w_pick_dbg) begin
                        r_state    <= S_ACCESS;
                        r_cnt      <= c_CNT_W'(MEM_LAT - 1);
                        r_mem_en   <= 1'b1;
                        r_gnt_core <= w_pick_core;
                        r_gnt_dbg  <= w_pick_dbg;
                        r_we       <= w_pick_core ? bus.core_we    : bus.dbg_we;
                        r_addr     <= w_pick_core ? bus.core_addr  : bus.dbg_addr;
                        r_wdata    <= w_pick_core ? bus.core_wdata : bus.dbg_wdata;
                        // A core win over a pending dbg can never happen at the limit, so no overflow.
                        if (w_pick_core && bus.dbg_req) begin
                            r_streak <= r_streak + 1'b1;
                        end else begin
                            r_streak <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state    <= S_RESP;
                        r_core_ack <= r_gnt_core;
                        r_dbg_ack  <= r_gnt_dbg;
                        if (!r_we) begin
                            if (r_gnt_core) begin
                                r_core_rdata <= bus.mem_rdata;
                            end else begin
                                r_dbg_rdata  <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_gnt_core <= 1'b0;
                    r_gnt_dbg  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_rdata = r_core_rdata;
    assign bus.core_ack   = r_core_ack;
    assign bus.core_stall = bus.core_req & ~r_core_ack;
    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.dbg_ack    = r_dbg_ack;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.grant_core = r_gnt_core;
    assign bus.grant_dbg  = r_gnt_dbg;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Brief    : Random and directed stimulus for dmem_port_arbiter against a
//             transaction-timeline reference model and a latency memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_LIM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus.slave)
    );

    // Memory: read data is presented only in the cycle the arbiter must sample it.
    bit   [DATA_W-1:0] env_mem [0:(1<<ADDR_W)-1];
    bit                rd_pend;
    int                rd_wait;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] junk;

    always @(posedge clk) begin
        junk <= {$urandom, $urandom};
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
            else begin
                rd_pend <= 1'b1;
                rd_addr <= bus.mem_addr;
                rd_wait <= MEM_LAT - 2;
            end
        end else if (rd_pend) begin
            if (rd_wait == 0) rd_pend <= 1'b0;
            else rd_wait <= rd_wait - 1;
        end
    end
    assign bus.mem_rdata = (rd_pend && rd_wait == 0) ? env_mem[rd_addr] : junk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int                rate [2];
    int                drop_pct;
    bit                a_active [2];
    bit                a_ackseen[2];
    bit                a_req    [2];
    bit                a_we     [2];
    logic [ADDR_W-1:0] a_addr   [2];
    logic [DATA_W-1:0] a_wdata  [2];

    bit                m_act;
    int                m_t0;
    int                m_owner;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    int                m_streak;
    bit   [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_rd [2];
    int                gnt_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'(($urandom_range(1) != 0 ? 32'h3F0 : 32'h0) | $urandom_range(15));
    endfunction

    task automatic new_req(input int p, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
        a_active[p] = 1'b1;
        a_req[p]    = 1'b1;
        a_we[p]     = we;
        a_addr[p]   = addr;
        a_wdata[p]  = wd;
    endtask

    task automatic apply_inputs();
        bus.core_req   = a_req[0];
        bus.core_we    = a_we[0];
        bus.core_addr  = a_addr[0];
        bus.core_wdata = a_wdata[0];
        bus.dbg_req    = a_req[1];
        bus.dbg_we     = a_we[1];
        bus.dbg_addr   = a_addr[1];
        bus.dbg_wdata  = a_wdata[1];
    endtask

    task automatic clear_agents();
        for (int p = 0; p < 2; p++) begin
            a_active[p]  = 1'b0;
            a_ackseen[p] = 1'b0;
            a_req[p]     = 1'b0;
            a_we[p]      = 1'b0;
            a_addr[p]    = '0;
            a_wdata[p]   = '0;
        end
        apply_inputs();
    endtask

    // Each granted transaction occupies the MEM_LAT+1 cycles after its arbitration cycle.
    task automatic model_check();
        bit e_gc, e_gd, e_busy, e_en, pick_core;
        bit e_ack[2];
        int k;
        e_gc = 1'b0; e_gd = 1'b0; e_busy = 1'b0; e_en = 1'b0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        k = 0;
        if (m_act) begin
            k      = cyc - m_t0;
            e_busy = 1'b1;
            e_gc   = (m_owner == 0);
            e_gd   = (m_owner == 1);
            e_en   = (k == 1);
            if (k == MEM_LAT + 1) begin
                e_ack[m_owner] = 1'b1;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      exp_rd[m_owner] = ref_mem[m_addr];
            end
        end
        chk("grant_core", 64'(bus.grant_core), 64'(e_gc));
        chk("grant_dbg",  64'(bus.grant_dbg),  64'(e_gd));
        chk("busy",       64'(bus.busy),       64'(e_busy));
        chk("mem_en",     64'(bus.mem_en),     64'(e_en));
        chk("core_ack",   64'(bus.core_ack),   64'(e_ack[0]));
        chk("dbg_ack",    64'(bus.dbg_ack),    64'(e_ack[1]));
        chk("core_stall", 64'(bus.core_stall), 64'(a_req[0] && !e_ack[0]));
        chk("core_rdata", bus.core_rdata, exp_rd[0]);
        chk("dbg_rdata",  bus.dbg_rdata,  exp_rd[1]);
        if (m_act && k <= MEM_LAT) begin
            chk("mem_we",   64'(bus.mem_we),   64'(m_we));
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (m_act) begin
            if (k == MEM_LAT + 1) m_act = 1'b0;
        end else if (a_req[0] || a_req[1]) begin
            pick_core = a_req[0] && !(a_req[1] && m_streak == STARVE_LIM);
            m_owner   = pick_core ? 0 : 1;
            m_act     = 1'b1;
            m_t0      = cyc;
            m_we      = a_we[m_owner];
            m_addr    = a_addr[m_owner];
            m_wdata   = a_wdata[m_owner];
            if (pick_core && a_req[1]) m_streak = (m_streak < STARVE_LIM) ? m_streak + 1 : STARVE_LIM;
            else                       m_streak = 0;
        end
    endtask

    task automatic step();
        bit ack_p, gnt_p;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) begin
            ack_p = (p == 0) ? bus.core_ack   : bus.dbg_ack;
            gnt_p = (p == 0) ? bus.grant_core : bus.grant_dbg;
            if (a_ackseen[p]) begin
                a_ackseen[p] = 1'b0;
                a_active[p]  = 1'b0;
                a_req[p]     = 1'b0;
            end
            if (!a_active[p]) begin
                if ($urandom_range(99) < rate[p])
                    new_req(p, 1'($urandom_range(1)), rand_addr(), {$urandom, $urandom});
            end else if (ack_p) begin
                a_ackseen[p] = 1'b1;
            end else if (gnt_p && $urandom_range(99) < drop_pct) begin
                a_req[p] = 1'b0;
            end
        end
        apply_inputs();
        #1;
        if (bus.mem_en === 1'b1) gnt_log.push_back(bus.grant_dbg ? 1 : 0);
        model_check();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((a_active[0] || a_active[1] || m_act) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 64'(a_active[0] || a_active[1] || m_act), 64'd0);
    endtask

    initial begin
        int n;
        int starve_exp[6];
        rate[0] = 0; rate[1] = 0; drop_pct = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        m_act = 1'b0; m_streak = 0;
        clear_agents();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // Preload via dbg, then core read with fixed latency.
        new_req(1, 1'b1, 10'h010, 64'hDEADBEEF_00000001);
        wait_idle(20, "t1_wr");
        new_req(0, 1'b0, 10'h010, 64'h0);
        wait_idle(20, "t1_rd");
        chk("t1_core_rdata", bus.core_rdata, 64'hDEADBEEF_00000001);

        new_req(1, 1'b1, 10'h020, 64'h5A);
        wait_idle(20, "t2_wr");
        new_req(0, 1'b0, 10'h020, 64'h0);
        wait_idle(20, "t2_rd");
        chk("t2_core_rdata", bus.core_rdata, 64'h5A);
        chk("t2_dbg_rdata",  bus.dbg_rdata,  64'h0);

        // Simultaneous requests.
        new_req(0, 1'b0, 10'h010, 64'h0);
        new_req(1, 1'b0, 10'h020, 64'h0);
        wait_idle(30, "t3");
        chk("t3_core_rdata", bus.core_rdata, 64'hDEADBEEF_00000001);
        chk("t3_dbg_rdata",  bus.dbg_rdata,  64'h5A);

        // Request dropped as soon as the grant is visible.
        drop_pct = 100;
        new_req(0, 1'b0, 10'h020, 64'h0);
        wait_idle(20, "t6");
        drop_pct = 0;
        step();
        chk("t6_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the first ACCESS cycle of a core read.
        new_req(0, 1'b0, 10'h3F5, 64'h0);
        n = 0;
        while (!(m_act && cyc - m_t0 == 1) && n < 20) begin step(); n++; end
        chk("t5_reached_access", 64'(m_act && cyc - m_t0 == 1), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_mem_en",     64'(bus.mem_en),     64'd0);
        chk("t5_grant_core", 64'(bus.grant_core), 64'd0);
        chk("t5_grant_dbg",  64'(bus.grant_dbg),  64'd0);
        chk("t5_busy",       64'(bus.busy),       64'd0);
        clear_agents();
        m_act = 1'b0; m_streak = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) step();
        chk("t5_core_rdata", bus.core_rdata, 64'h0);

        // Starvation: both ports always requesting.
        gnt_log.delete();
        rate[0] = 100; rate[1] = 100;
        n = 0;
        while (gnt_log.size() < 6 && n < 100) begin step(); n++; end
        rate[0] = 0; rate[1] = 0;
        starve_exp = '{0, 0, 0, 0, 1, 0};
        chk("t4_grant_count", 64'(gnt_log.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk($sformatf("t4_grant_%0d", i), 64'(gnt_log[i]), 64'(starve_exp[i]));
        wait_idle(40, "t4");

        // Random traffic.
        for (int r = 0; r < 4; r++) begin
            rate[0]  = $urandom_range(20, 90);
            rate[1]  = $urandom_range(10, 90);
            drop_pct = $urandom_range(0, 40);
            repeat (400) step();
        end
        rate[0] = 0; rate[1] = 0;
        wait_idle(40, "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
